// File: rtl/mem_port_initiator.sv
// mem_port_initiator: initiator side of a single-ported, byte-addressable
// unified instruction/data memory. Arbitrates fetch vs load/store (data wins),
// drives funct3-coded memory strobes, registers read data and returns a
// one-cycle response pulse to the requester.
//
// Optional feature: define MISALIGN_SPLIT_EN to split misaligned H/W accesses
// into sequential byte accesses (SPLIT state). Without it, misaligned H/W
// accesses get the error response and no SPLIT logic is built.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   if_req/if_addr      fetch request in; if_ready accept, if_valid/if_instr response
//   d_req/d_we/d_f3/
//   d_addr/d_wdata      load/store request in; d_ready accept
//   d_rvalid/d_rdata/
//   d_err               load/store completion pulse, extended result, error flag
//   mem_*               memory strobes, width code, address, write/read data
module mem_port_initiator #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_f3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        mem_f3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, FETCH, DACC
`ifdef MISALIGN_SPLIT_EN
    , SPLIT
`endif
  } state_t;

  state_t            state, nxt;
  logic              q_we, q_err;
  logic [2:0]        q_f3;
  logic [ADDR_W-1:0] q_addr;   // shared by fetch and data; fetch masks [1:0] on output
  logic [31:0]       q_wdata;

  // request decode at acceptance
  logic ill, mis, acc_err;
  assign ill = (d_f3 == 3'b011) | (d_f3 == 3'b110) | (d_f3 == 3'b111) | (d_f3[2] & d_we);
  assign mis = ((d_f3[1:0] == 2'b01) & d_addr[0]) |
               ((d_f3[1:0] == 2'b10) & (d_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
  logic        acc_split;
  logic [1:0]  k, k_last;
  logic [31:0] asm_q, asm_nxt, asm_ext;
  logic [7:0]  wbyte;
  assign acc_err   = ill;
  assign acc_split = !ill & mis;
  assign k_last    = (q_f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign wbyte     = 8'(q_wdata >> {k, 3'b000});
  assign asm_nxt   = asm_q | (32'(mem_rdata[7:0]) << {k, 3'b000});
  always_comb begin
    asm_ext = asm_nxt;
    if (q_f3 == 3'b001)      asm_ext = {{16{asm_nxt[15]}}, asm_nxt[15:0]};
    else if (q_f3 == 3'b101) asm_ext = {16'h0, asm_nxt[15:0]};
  end
`else
  assign acc_err = ill | mis;
`endif

  // Strobes are gated by rst so an access in flight when reset is sampled
  // never commits: a partial split store stops at the reset cycle itself.
  always_comb begin
    nxt       = state;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_f3    = 3'b000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        d_ready  = 1'b1;
        if_ready = !d_req;
        if (d_req) begin
`ifdef MISALIGN_SPLIT_EN
          nxt = acc_split ? SPLIT : DACC;
`else
          nxt = DACC;
`endif
        end else if (if_req) nxt = FETCH;
      end
      FETCH: begin
        mem_rd   = rst;
        mem_f3   = 3'b010;
        mem_addr = {q_addr[ADDR_W-1:2], 2'b00};
        nxt      = IDLE;
      end
      DACC: begin
        if (!q_err) begin
          mem_rd    = rst & !q_we;
          mem_wr    = rst & q_we;
          mem_f3    = q_f3;
          mem_addr  = q_addr;
          mem_wdata = q_wdata;
        end
        nxt = IDLE;
      end
`ifdef MISALIGN_SPLIT_EN
      SPLIT: begin
        mem_rd    = rst & !q_we;
        mem_wr    = rst & q_we;
        mem_f3    = q_we ? 3'b000 : 3'b100;
        mem_addr  = q_addr + ADDR_W'(k);
        mem_wdata = {24'h0, wbyte};
        if (k == k_last) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      q_we     <= 1'b0;
      q_err    <= 1'b0;
      q_f3     <= 3'b000;
      q_addr   <= '0;
      q_wdata  <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      k        <= 2'd0;
      asm_q    <= '0;
`endif
    end else begin
      state    <= nxt;
      if_valid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            q_we    <= d_we;
            q_f3    <= d_f3;
            q_addr  <= d_addr;
            q_wdata <= d_wdata;
            q_err   <= acc_err;
`ifdef MISALIGN_SPLIT_EN
            k       <= 2'd0;
            asm_q   <= '0;
`endif
          end else if (if_req) begin
            q_addr <= if_addr;
          end
        end
        FETCH: begin
          if_instr <= mem_rdata;
          if_valid <= 1'b1;
        end
        DACC: begin
          d_rvalid <= 1'b1;
          d_err    <= q_err;
          d_rdata  <= (q_err | q_we) ? 32'h0 : mem_rdata;
        end
`ifdef MISALIGN_SPLIT_EN
        SPLIT: begin
          asm_q <= asm_nxt;
          k     <= k + 2'd1;
          if (k == k_last) begin
            d_rvalid <= 1'b1;
            d_rdata  <= q_we ? 32'h0 : asm_ext;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
